// File: rtl/cmult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmult_pkg
// Description : Shared width helpers and complex-pair typedef for the
//               complex multiplier and the butterfly blocks that use it.
//               full_w : width of one signed product (2*DATA_W+1)
//               acc_w  : width of a sum/difference of two products
//               needs_sat : whether the scaled result can exceed OUT_W
// Revision    : 1.0 - initial release
// ============================================================================
package cmult_pkg;

  localparam int PAIR_W = 64;

  // Generic {real, imag} container exchanged with butterfly/twiddle stages.
  typedef struct packed {
    logic signed [PAIR_W-1:0] re;
    logic signed [PAIR_W-1:0] im;
  } cplx_pair_t;

  function automatic int full_w(input int data_w);
    return 2 * data_w + 1;
  endfunction

  function automatic int acc_w(input int data_w);
    return 2 * data_w + 2;
  endfunction

  // Saturation bound helper: the scaled result fits in full_w-shift bits,
  // so clamping logic is only needed when the output is narrower than that.
  function automatic bit needs_sat(input int data_w, input int shift, input int out_w);
    return out_w < (full_w(data_w) - shift);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmult_if.sv
`default_nettype none
// ============================================================================
// Module      : cmult_if
// Description : Valid/ready stream bundle of the complex multiplier.
//               Input side : s_valid_i, s_ready_o, a/b operands, conj_i
//               Output side: m_valid_o, m_ready_i, p_real_o, p_imag_o, ovf_o
//               slave modport is the multiplier, master modport the user.
// Revision    : 1.0 - initial release
// ============================================================================
interface cmult_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 33
);
  logic                     s_valid_i;
  logic                     s_ready_o;
  logic signed [DATA_W-1:0] a_real_i;
  logic signed [DATA_W-1:0] a_imag_i;
  logic signed [DATA_W-1:0] b_real_i;
  logic signed [DATA_W-1:0] b_imag_i;
  logic                     conj_i;
  logic                     m_valid_o;
  logic                     m_ready_i;
  logic signed [OUT_W-1:0]  p_real_o;
  logic signed [OUT_W-1:0]  p_imag_o;
  logic                     ovf_o;

  modport slave (
    input  s_valid_i, a_real_i, a_imag_i, b_real_i, b_imag_i, conj_i, m_ready_i,
    output s_ready_o, m_valid_o, p_real_o, p_imag_o, ovf_o
  );

  modport master (
    output s_valid_i, a_real_i, a_imag_i, b_real_i, b_imag_i, conj_i, m_ready_i,
    input  s_ready_o, m_valid_o, p_real_o, p_imag_o, ovf_o
  );
endinterface
`default_nettype wire

// File: rtl/cmult_round_sat.sv
`default_nettype none
// ============================================================================
// Module      : cmult_round_sat
// Description : Combinational scale (arithmetic shift right by SHIFT),
//               optional round-half-up, and saturation of one component.
//               Macro CMULT_ROUND_EN selects rounding; otherwise truncation.
//   x_i   in  acc_w(DATA_W)  full-precision signed value
//   y_o   out OUT_W          scaled, saturated value
//   ovf_o out 1              value was clamped
// Revision    : 1.0 - initial release
// ============================================================================
module cmult_round_sat
  import cmult_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SHIFT  = 0,
  parameter int OUT_W  = 33,
  localparam int IN_W  = acc_w(DATA_W)
) (
  input  logic signed [IN_W-1:0]  x_i,
  output logic signed [OUT_W-1:0] y_o,
  output logic                    ovf_o
);

  logic signed [IN_W-1:0] w_biased;
  logic signed [IN_W-1:0] w_shifted;

  // The extra headroom bit of IN_W guarantees the rounding add cannot wrap.
  generate
    if (SHIFT > 0) begin : g_bias
`ifdef CMULT_ROUND_EN
      localparam logic signed [IN_W-1:0] HALF = IN_W'(1) << (SHIFT - 1);
      assign w_biased = x_i + HALF;
`else
      assign w_biased = x_i;
`endif
    end else begin : g_no_bias
      assign w_biased = x_i;
    end
  endgenerate

  assign w_shifted = w_biased >>> SHIFT;

  generate
    if (needs_sat(DATA_W, SHIFT, OUT_W)) begin : g_sat
      localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      always_comb begin
        y_o   = OUT_W'(w_shifted);
        ovf_o = 1'b0;
        if (w_shifted > MAX_V) begin
          y_o   = {1'b0, {(OUT_W-1){1'b1}}};
          ovf_o = 1'b1;
        end else if (w_shifted < MIN_V) begin
          y_o   = {1'b1, {(OUT_W-1){1'b0}}};
          ovf_o = 1'b1;
        end
      end
    end else begin : g_ext
      // Output wide enough for every scaled value: plain resize/sign-extend.
      assign y_o   = OUT_W'(w_shifted);
      assign ovf_o = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/complex_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : complex_mult_pipe
// Description : 3-stage pipelined signed complex multiplier P = A * B or
//               A * conj(B), with valid/ready flow control, scaling and
//               saturation. Optional rounding via macro CMULT_ROUND_EN.
//   sys_clk_i  in   clock, rising edge
//   rst_n_i    in   asynchronous active-low reset
//   bus        slave modport of cmult_if (stream in/out, see cmult_if)
// Revision    : 1.0 - initial release
// ============================================================================
module complex_mult_pipe
  import cmult_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SHIFT  = 0,
  parameter int OUT_W  = 33
) (
  input  logic   sys_clk_i,
  input  logic   rst_n_i,
  cmult_if.slave bus
);

  localparam int FULL_W = full_w(DATA_W);
  localparam int ACC_W  = acc_w(DATA_W);
  localparam int BI_W   = DATA_W + 1;

  // S1: registered operands
  logic                     v1_q,   v1_d;
  logic signed [DATA_W-1:0] ar1_q,  ar1_d;
  logic signed [DATA_W-1:0] ai1_q,  ai1_d;
  logic signed [DATA_W-1:0] br1_q,  br1_d;
  logic signed [BI_W-1:0]   bie1_q, bie1_d;
  // S2: partial products
  logic                     v2_q,   v2_d;
  logic signed [FULL_W-1:0] rr2_q,  rr2_d;
  logic signed [FULL_W-1:0] ii2_q,  ii2_d;
  logic signed [FULL_W-1:0] ri2_q,  ri2_d;
  logic signed [FULL_W-1:0] ir2_q,  ir2_d;
  // S3: output register
  logic                     mv_q,   mv_d;
  logic signed [OUT_W-1:0]  pre_q,  pre_d;
  logic signed [OUT_W-1:0]  pim_q,  pim_d;
  logic                     ovf_q,  ovf_d;

  logic                     w_ce;
  logic signed [BI_W-1:0]   w_bi_ext;
  logic signed [BI_W-1:0]   w_bi_eff;
  logic signed [ACC_W-1:0]  w_re_acc;
  logic signed [ACC_W-1:0]  w_im_acc;
  logic signed [OUT_W-1:0]  w_re_sat;
  logic signed [OUT_W-1:0]  w_im_sat;
  logic                     w_ovf_re;
  logic                     w_ovf_im;

  // One extra bit so negating the most negative imag value stays exact.
  assign w_bi_ext = BI_W'(bus.b_imag_i);
  assign w_bi_eff = bus.conj_i ? -w_bi_ext : w_bi_ext;

  assign w_re_acc = ACC_W'(rr2_q) - ACC_W'(ii2_q);
  assign w_im_acc = ACC_W'(ri2_q) + ACC_W'(ir2_q);

  cmult_round_sat #(.DATA_W(DATA_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rs_real (
    .x_i   (w_re_acc),
    .y_o   (w_re_sat),
    .ovf_o (w_ovf_re)
  );

  cmult_round_sat #(.DATA_W(DATA_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rs_imag (
    .x_i   (w_im_acc),
    .y_o   (w_im_sat),
    .ovf_o (w_ovf_im)
  );

  always_comb begin
    // Whole pipe advances in lock-step whenever the output slot is free.
    w_ce   = ~mv_q | bus.m_ready_i;
    v1_d   = v1_q;   ar1_d = ar1_q; ai1_d = ai1_q; br1_d = br1_q; bie1_d = bie1_q;
    v2_d   = v2_q;   rr2_d = rr2_q; ii2_d = ii2_q; ri2_d = ri2_q; ir2_d  = ir2_q;
    mv_d   = mv_q;   pre_d = pre_q; pim_d = pim_q; ovf_d = ovf_q;
    if (w_ce) begin
      v1_d = bus.s_valid_i;
      if (bus.s_valid_i) begin
        ar1_d  = bus.a_real_i;
        ai1_d  = bus.a_imag_i;
        br1_d  = bus.b_real_i;
        bie1_d = w_bi_eff;
      end
      v2_d = v1_q;
      if (v1_q) begin
        rr2_d = FULL_W'(ar1_q) * FULL_W'(br1_q);
        ii2_d = FULL_W'(ai1_q) * FULL_W'(bie1_q);
        ri2_d = FULL_W'(ar1_q) * FULL_W'(bie1_q);
        ir2_d = FULL_W'(ai1_q) * FULL_W'(br1_q);
      end
      mv_d = v2_q;
      if (v2_q) begin
        pre_d = w_re_sat;
        pim_d = w_im_sat;
        ovf_d = w_ovf_re | w_ovf_im;
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1_q <= 1'b0; ar1_q <= '0; ai1_q <= '0; br1_q <= '0; bie1_q <= '0;
      v2_q <= 1'b0; rr2_q <= '0; ii2_q <= '0; ri2_q <= '0; ir2_q  <= '0;
      mv_q <= 1'b0; pre_q <= '0; pim_q <= '0; ovf_q <= 1'b0;
    end else begin
      v1_q <= v1_d; ar1_q <= ar1_d; ai1_q <= ai1_d; br1_q <= br1_d; bie1_q <= bie1_d;
      v2_q <= v2_d; rr2_q <= rr2_d; ii2_q <= ii2_d; ri2_q <= ri2_d; ir2_q  <= ir2_d;
      mv_q <= mv_d; pre_q <= pre_d; pim_q <= pim_d; ovf_q <= ovf_d;
    end
  end

  assign bus.s_ready_o = w_ce;
  assign bus.m_valid_o = mv_q;
  assign bus.p_real_o  = pre_q;
  assign bus.p_imag_o  = pim_q;
  assign bus.ovf_o     = ovf_q;

endmodule
`default_nettype wire
